// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default geometry and the
// FSM state encoding that is also exported on the `state` port.
package fifo_ctrl_pkg;

  localparam int DEF_PTR       = 3;
  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_WORD_SIZE = 10;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } fifo_state_e;

  // Requests are only ever honoured in these two states.
  function automatic logic is_running(input fifo_state_e s);
    return (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// PTR-bit wrapping address counter used for both memory pointers.
// Ports:
//   clk, reset : clock, async active-low reset
//   en         : advance by one on this edge
//   clr        : return to zero on this edge (wins over en)
//   ptr        : registered pointer value
module fifo_ctrl_ptr_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)     ptr_d = '0;
    else if (en) ptr_d = ptr_q + W'(1);  // natural wrap at 2**W
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Control unit for a MEM_SIZE x WORD_SIZE push/pop memory. Decides which
// producer/consumer requests are accepted, drives the memory strobes and
// pointers, tracks occupancy and raises status / error flags. Data does not
// pass through this block.
// Ports:
//   clk, reset              : clock, async active-low reset
//   init                    : (re)configure, load thresholds, flush
//   thr_high, thr_low       : almost-full / almost-empty thresholds
//   push_req, pop_req       : producer / consumer requests
//   push, pop               : memory strobes (combinational, same-edge)
//   wr_ptr, rd_ptr          : memory addresses (registered)
//   valid_out               : read data valid, one cycle after pop
//   count                   : words stored, 0..MEM_SIZE
//   fifo_full .. almost_empty : registered status flags
//   error                   : sticky overflow/underflow
//   state                   : current FSM state
//
// state  | meaning
// RESET  | leaving reset, goes to INIT on the next edge
// INIT   | load thresholds, flush pointers/count/error
// IDLE   | running, nothing stored
// ACTIVE | running, at least one word stored
// ERROR  | overflow/underflow seen; frozen until init
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic [PTR:0]   thr_high,
  input  logic [PTR:0]   thr_low,
  input  logic           push_req,
  input  logic           pop_req,
  output logic           push,
  output logic           pop,
  output logic [PTR-1:0] wr_ptr,
  output logic [PTR-1:0] rd_ptr,
  output logic           valid_out,
  output logic [PTR:0]   count,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           error,
  output logic [2:0]     state
);

  localparam int CNT_W = PTR + 1;

  if (MEM_SIZE != (1 << PTR) || WORD_SIZE < 1) begin : g_bad_cfg
    $error("fifo_ctrl: MEM_SIZE must equal 2**PTR and WORD_SIZE must be positive");
  end

  fifo_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] thr_high_q, thr_high_d;
  logic [CNT_W-1:0] thr_low_q, thr_low_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             error_q, error_d;
  logic             valid_q, valid_d;

  logic run, pop_acc, push_acc, overflow, underflow;

  // Acceptance decisions are made against the registered flags so the memory
  // strobes settle early in the cycle.
  always_comb begin
    run       = is_running(state_q) && !init;
    pop_acc   = run && pop_req && !empty_q;
    underflow = run && pop_req && empty_q;
    overflow  = run && push_req && full_q && !pop_acc;
    // No bypass when empty: a simultaneous pop is an underflow and kills the push.
    push_acc  = run && push_req && !underflow && (!full_q || pop_acc);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (init)                       state_d = ST_INIT;
        else if (overflow || underflow) state_d = ST_ERROR;
        else if (count_d == '0)         state_d = ST_IDLE;
        else                            state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = init ? ST_INIT : ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  // FSM: outputs, occupancy and flags
  always_comb begin
    count_d    = count_q;
    thr_high_d = thr_high_q;
    thr_low_d  = thr_low_q;
    error_d    = error_q;
    unique case (state_q)
      ST_RESET: begin
        count_d = '0;
        error_d = 1'b0;
      end
      ST_INIT: begin
        count_d    = '0;
        error_d    = 1'b0;
        thr_high_d = thr_high;
        thr_low_d  = thr_low;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (push_acc && !pop_acc)      count_d = count_q + CNT_W'(1);
        else if (pop_acc && !push_acc) count_d = count_q - CNT_W'(1);
        error_d = error_q || overflow || underflow;
      end
      default: ;
    endcase

    full_d   = (count_d == CNT_W'(MEM_SIZE));
    empty_d  = (count_d == '0);
    afull_d  = is_running(state_d) && (count_d >= thr_high_d);
    aempty_d = is_running(state_d) && (count_d <= thr_low_d);
    valid_d  = pop_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      thr_high_q <= '0;
      thr_low_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      thr_high_q <= thr_high_d;
      thr_low_q  <= thr_low_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
    end
  end

  fifo_ctrl_ptr_counter #(.W(PTR)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_acc),
    .clr   (state_q == ST_INIT),
    .ptr   (wr_ptr)
  );

  fifo_ctrl_ptr_counter #(.W(PTR)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_acc),
    .clr   (state_q == ST_INIT),
    .ptr   (rd_ptr)
  );

  assign push         = push_acc;
  assign pop          = pop_acc;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign error        = error_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural memory attached. A queue-based
// reference model predicts every cycle; read data expected from accepted pops
// goes into a scoreboard that a separate monitor drains on valid_out.
module tb_fifo_ctrl;
  localparam int PTR = 3;
  localparam int MEM = 8;
  localparam int WS  = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           init = 1'b0;
  logic [PTR:0]   thr_high = '0;
  logic [PTR:0]   thr_low = '0;
  logic           push_req = 1'b0;
  logic           pop_req = 1'b0;
  logic           push, pop, valid_out, fifo_full, fifo_empty;
  logic           almost_full, almost_empty, error;
  logic [PTR-1:0] wr_ptr, rd_ptr;
  logic [PTR:0]   count;
  logic [2:0]     state;

  logic [WS-1:0]  data_in = '0;
  logic [WS-1:0]  data_out;
  logic [WS-1:0]  mem [MEM];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  int            m_state, m_wr, m_rd, m_thr_h, m_thr_l;
  bit            m_err, m_valid;
  logic [WS-1:0] m_q[$];
  logic [WS-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_ctrl #(.MEM_SIZE(MEM), .WORD_SIZE(WS), .PTR(PTR)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .thr_high     (thr_high),
    .thr_low      (thr_low),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .valid_out    (valid_out),
    .count        (count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .state        (state)
  );

  // behavioural memory driven by the controller
  always @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
    if (pop)  data_out    <= mem[rd_ptr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && valid_out === 1'b1) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'(exp_q.size()), 32'd1);
      else                   check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    m_state = 0; m_wr = 0; m_rd = 0; m_thr_h = 0; m_thr_l = 0;
    m_err = 1'b0; m_valid = 1'b0;
    m_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs();
    int  n;
    bit  run;
    n   = m_q.size();
    run = (m_state == 2) || (m_state == 3);
    check("state",        32'(state),        32'(m_state));
    check("count",        32'(count),        32'(n));
    check("wr_ptr",       32'(wr_ptr),       32'(m_wr));
    check("rd_ptr",       32'(rd_ptr),       32'(m_rd));
    check("fifo_full",    32'(fifo_full),    32'(n == MEM));
    check("fifo_empty",   32'(fifo_empty),   32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(run && n >= m_thr_h));
    check("almost_empty", 32'(almost_empty), 32'(run && n <= m_thr_l));
    check("error",        32'(error),        32'(m_err));
    check("valid_out",    32'(valid_out),    32'(m_valid));
  endtask

  task automatic step(input bit pu, input bit po, input bit in_init,
                      input logic [PTR:0] th, input logic [PTR:0] tl,
                      input logic [WS-1:0] d);
    int n;
    bit run, pop_a, push_a, over, under;
    @(negedge clk);
    push_req = pu; pop_req = po; init = in_init;
    thr_high = th; thr_low = tl; data_in = d;
    n      = m_q.size();
    run    = (m_state == 2 || m_state == 3) && !in_init;
    pop_a  = run && po && n > 0;
    under  = run && po && n == 0;
    over   = run && pu && n == MEM && !pop_a;
    push_a = run && pu && !under && !over;
    #1;
    check("push", 32'(push), 32'(push_a));
    check("pop",  32'(pop),  32'(pop_a));
    @(posedge clk);
    #1;
    case (m_state)
      0: m_state = 1;
      1: begin
        m_thr_h = int'(th); m_thr_l = int'(tl);
        m_q.delete(); m_wr = 0; m_rd = 0; m_err = 1'b0;
        m_state = in_init ? 1 : 2;
      end
      2, 3: begin
        if (in_init) m_state = 1;
        else if (over || under) begin
          m_err = 1'b1;
          m_state = 4;
        end else begin
          if (pop_a) begin
            exp_q.push_back(m_q.pop_front());
            m_rd = (m_rd + 1) % MEM;
          end
          if (push_a) begin
            m_q.push_back(d);
            m_wr = (m_wr + 1) % MEM;
          end
          m_state = (m_q.size() == 0) ? 2 : 3;
        end
      end
      default: m_state = in_init ? 1 : 4;
    endcase
    m_valid = pop_a;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    push_req = 1'b0; pop_req = 1'b0; init = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  logic [PTR:0] cur_th, cur_tl;
  bit           r_pu, r_po, r_in;

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 check_regs();
    @(posedge clk);
    #2 reset = 1'b1;

    // configure thr_high=6, thr_low=2, then fill to full
    step(0, 0, 1, 4'd6, 4'd2, '0);
    step(0, 0, 1, 4'd6, 4'd2, '0);
    step(0, 0, 0, 4'd6, 4'd2, '0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 4'd6, 4'd2, (i == 0) ? 10'h155 : (i == 1) ? 10'h2AA : WS'($urandom));
    check("full_wrap_wr_ptr", 32'(wr_ptr), 32'd0);

    // full: push & pop together
    step(1, 1, 0, 4'd6, 4'd2, WS'($urandom));
    // overflow, then pop ignored while in ERROR, then recover
    step(1, 0, 0, 4'd6, 4'd2, WS'($urandom));
    step(0, 1, 0, 4'd6, 4'd2, '0);
    step(0, 0, 1, 4'd6, 4'd2, '0);
    step(0, 0, 0, 4'd6, 4'd2, '0);

    // two known words through the memory
    step(1, 0, 0, 4'd6, 4'd2, 10'h155);
    step(1, 0, 0, 4'd6, 4'd2, 10'h2AA);
    step(0, 1, 0, 4'd6, 4'd2, '0);
    step(0, 1, 0, 4'd6, 4'd2, '0);
    step(0, 0, 0, 4'd6, 4'd2, '0);

    // empty: push & pop together -> underflow
    step(1, 1, 0, 4'd6, 4'd2, WS'($urandom));
    step(0, 0, 1, 4'd6, 4'd2, '0);
    step(0, 0, 0, 4'd6, 4'd2, '0);

    // randomized traffic with occasional reconfiguration and rare errors
    cur_th = 4'd6; cur_tl = 4'd2;
    for (int i = 0; i < 400; i++) begin
      r_pu = 1'b0; r_po = 1'b0; r_in = 1'b0;
      if (m_state == 4 || $urandom_range(0, 59) == 0) begin
        r_in   = 1'b1;
        cur_th = 4'($urandom_range(0, 15));
        cur_tl = 4'($urandom_range(0, 15));
      end else if (m_state == 1) begin
        r_in = ($urandom_range(0, 3) == 0);
      end else begin
        r_pu = ($urandom_range(0, 99) < ((i < 200) ? 65 : 40));
        r_po = ($urandom_range(0, 99) < ((i < 200) ? 40 : 65));
        if (r_po && m_q.size() == 0 && $urandom_range(0, 9) != 0) r_po = 1'b0;
        if (r_pu && m_q.size() == MEM && !r_po && $urandom_range(0, 9) != 0) r_pu = 1'b0;
      end
      if (r_in) begin
        r_pu = 1'($urandom_range(0, 1));
        r_po = 1'($urandom_range(0, 1));
      end
      step(r_pu, r_po, r_in, cur_th, cur_tl, WS'($urandom));
    end

    // reach count=5, then reset mid-cycle
    step(0, 0, 1, 4'd6, 4'd2, '0);
    step(0, 0, 0, 4'd6, 4'd2, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4'd6, 4'd2, WS'($urandom));
    check("pre_reset_count", 32'(count), 32'd5);
    do_reset();

    // recovery after reset
    step(0, 0, 1, 4'd3, 4'd1, '0);
    step(0, 0, 0, 4'd3, 4'd1, '0);
    step(1, 0, 0, 4'd3, 4'd1, 10'h0F0);
    step(0, 1, 0, 4'd3, 4'd1, '0);
    step(0, 0, 0, 4'd3, 4'd1, '0);
    step(0, 0, 0, 4'd3, 4'd1, '0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
